// File: rtl/mem_bist_pkg.sv
// Shared types and the March C- element table for the memory BIST controller.
package mem_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    W0 = 2'd0,
    W1 = 2'd1,
    R0 = 2'd2,
    R1 = 2'd3
  } op_t;

  // One march element: how many ops per address, which ops, and the address direction.
  typedef struct packed {
    logic [1:0] n_ops;
    op_t        op0;
    op_t        op1;
    logic       down;
  } elem_t;

  localparam int         NUM_ELEMS = 6;
  localparam logic [2:0] LAST_ELEM = 3'd5;

  // Background pattern bits; replicated to the data width by the controller.
  localparam logic BG_ZEROS = 1'b0;
  localparam logic BG_ONES  = 1'b1;

  // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
  localparam elem_t MARCH_TABLE [0:NUM_ELEMS-1] = '{
    '{n_ops: 2'd1, op0: W0, op1: W0, down: 1'b0},
    '{n_ops: 2'd2, op0: R0, op1: W1, down: 1'b0},
    '{n_ops: 2'd2, op0: R1, op1: W0, down: 1'b0},
    '{n_ops: 2'd2, op0: R0, op1: W1, down: 1'b1},
    '{n_ops: 2'd2, op0: R1, op1: W0, down: 1'b1},
    '{n_ops: 2'd1, op0: R0, op1: R0, down: 1'b0}
  };

  function automatic logic op_is_write(input op_t op);
    return (op == W0) || (op == W1);
  endfunction

  function automatic logic op_value(input op_t op);
    return ((op == W1) || (op == R1)) ? BG_ONES : BG_ZEROS;
  endfunction

endpackage

// File: rtl/mem_bist_addr_gen.sv
// Loadable up/down address counter; tc flags the last address of the current direction.
module mem_bist_addr_gen #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              step,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              tc
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  // Address register: load has priority over stepping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_val;
    end else if (step) begin
      addr <= down ? (addr - ADDR_ONE) : (addr + ADDR_ONE);
    end
  end

  assign tc = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/mem_bist_march.sv
// March C- BIST controller driving a single-port SRAM, with first-failure capture.
module mem_bist_march
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [DATA_W-1:0] fail_expected,
  output logic [2:0]        fail_element,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state, state_nxt;
  logic [2:0]        elem_idx;
  logic              op_idx;
  elem_t             cur_elem;
  op_t               cur_op;
  logic              last_op_in_elem;
  logic              in_run;
  logic              elem_end;
  logic              march_end;
  logic              accept_start;
  logic              rd_issue;

  logic              ag_load;
  logic [ADDR_W-1:0] ag_load_val;
  logic              ag_step;
  logic [ADDR_W-1:0] addr;
  logic              addr_tc;

  logic              cmp_pending;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;
  logic [2:0]        cmp_elem;

  assign cur_elem        = MARCH_TABLE[elem_idx];
  assign cur_op          = op_idx ? cur_elem.op1 : cur_elem.op0;
  assign last_op_in_elem = (cur_elem.n_ops == 2'd1) || op_idx;
  assign in_run          = (state == RUN);
  assign elem_end        = in_run && last_op_in_elem && addr_tc;
  assign march_end       = elem_end && (elem_idx == LAST_ELEM);
  assign accept_start    = start && ((state == IDLE) || (state == DONE));
  assign rd_issue        = in_run && !op_is_write(cur_op);

  // The counter starts each element at its first address; up elements at 0, down at N-1.
  assign ag_load     = accept_start || (elem_end && !march_end);
  assign ag_load_val = accept_start ? '0 :
                       (MARCH_TABLE[elem_idx + 3'd1].down ? '1 : '0);
  assign ag_step     = in_run && last_op_in_elem && !addr_tc;

  mem_bist_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (ag_load),
    .load_val (ag_load_val),
    .step     (ag_step),
    .down     (cur_elem.down),
    .addr     (addr),
    .tc       (addr_tc)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: start is only honoured when no test is in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = RUN;
      RUN:     if (march_end) state_nxt = DRAIN;
      DRAIN:                  state_nxt = DONE;
      DONE:    if (start)     state_nxt = RUN;
      default:                state_nxt = IDLE;
    endcase
  end

  // FSM outputs: SRAM controls come straight from registered state, idle values are all zero.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (state)
      RUN: begin
        busy     = 1'b1;
        mem_addr = addr;
        if (op_is_write(cur_op)) begin
          mem_we    = 1'b1;
          mem_wdata = {DATA_W{op_value(cur_op)}};
        end else begin
          mem_re = 1'b1;
        end
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign pass = done && !fail;

  // Element / op sequencing; address stepping lives in the address generator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_idx <= '0;
      op_idx   <= 1'b0;
    end else if (accept_start) begin
      elem_idx <= '0;
      op_idx   <= 1'b0;
    end else if (in_run) begin
      if (!last_op_in_elem) begin
        op_idx <= 1'b1;
      end else begin
        op_idx <= 1'b0;
        if (addr_tc && (elem_idx != LAST_ELEM)) begin
          elem_idx <= elem_idx + 3'd1;
        end
      end
    end
  end

  // Read bookkeeping: remember what the SRAM should return on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_pending <= 1'b0;
      cmp_exp     <= '0;
      cmp_addr    <= '0;
      cmp_elem    <= '0;
    end else begin
      cmp_pending <= rd_issue;
      if (rd_issue) begin
        cmp_exp  <= {DATA_W{op_value(cur_op)}};
        cmp_addr <= addr;
        cmp_elem <= elem_idx;
      end
    end
  end

  // First-failure capture; mem_rdata is only looked at when a read is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail          <= 1'b0;
      fail_addr     <= '0;
      fail_data     <= '0;
      fail_expected <= '0;
      fail_element  <= '0;
    end else if (accept_start) begin
      fail          <= 1'b0;
      fail_addr     <= '0;
      fail_data     <= '0;
      fail_expected <= '0;
      fail_element  <= '0;
    end else if (cmp_pending && !fail && (mem_rdata != cmp_exp)) begin
      fail          <= 1'b1;
      fail_addr     <= cmp_addr;
      fail_data     <= mem_rdata;
      fail_expected <= cmp_exp;
      fail_element  <= cmp_elem;
    end
  end

endmodule

// File: tb/tb_mem_bist_march.sv
// Bench for mem_bist_march: SRAM model with read-fault shim, op and result scoreboards.
module tb_mem_bist_march;

  localparam int AW      = 4;
  localparam int DW      = 8;
  localparam int N       = 16;
  localparam int RUN_OPS = 10 * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, pass, fail;
  logic [AW-1:0] fail_addr, mem_addr;
  logic [DW-1:0] fail_data, fail_expected, mem_wdata, mem_rdata;
  logic [2:0]    fail_element;
  logic          mem_we, mem_re;

  mem_bist_march #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .fail          (fail),
    .fail_addr     (fail_addr),
    .fail_data     (fail_data),
    .fail_expected (fail_expected),
    .fail_element  (fail_element),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_re        (mem_re),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SRAM model: registered read (old data on read-then-write), fault shim on the read path.
  logic [DW-1:0] sram [N];
  logic [DW-1:0] rd_q = '0;
  logic [DW-1:0] rd_raw;
  logic          rd_v = 1'b0;
  int            rd_cnt = 0;
  int            fault_mode = 0;

  always @(posedge clk) begin
    rd_v <= mem_re;
    if (!busy) rd_cnt <= 0;
    if (mem_re) begin
      rd_raw = sram[mem_addr];
      if (fault_mode == 1 && mem_addr == 4'd5) rd_raw[0] = 1'b1;
      if (fault_mode == 2 && (rd_cnt == 9 || rd_cnt == 19)) rd_raw[0] = ~rd_raw[0];
      rd_q   <= rd_raw;
      rd_cnt <= rd_cnt + 1;
    end
    if (mem_we) sram[mem_addr] <= mem_wdata;
  end

  assign mem_rdata = rd_v ? rd_q : 'x;

  typedef struct {
    logic          we;
    logic          re;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            at;
  } op_exp_t;

  typedef struct {
    logic          pass_v;
    logic          fail_v;
    logic [AW-1:0] faddr;
    logic [DW-1:0] fdata;
    logic [DW-1:0] fexp;
    logic [2:0]    felem;
    int            done_at;
  } res_exp_t;

  op_exp_t  op_q[$];
  res_exp_t res_q[$];

  // Hand-written March C- description: ops per element, direction, read value of the pair.
  int e_nops [6] = '{1, 2, 2, 2, 2, 1};
  bit e_down [6] = '{0, 0, 0, 1, 1, 0};
  bit e_rval [6] = '{0, 0, 1, 0, 1, 0};

  task automatic push_ops(input int t);
    int k = 0;
    for (int e = 0; e < 6; e++) begin
      for (int j = 0; j < N; j++) begin
        for (int o = 0; o < e_nops[e]; o++) begin
          op_exp_t x;
          x.addr = AW'(e_down[e] ? (N - 1 - j) : j);
          x.at   = t + 1 + k;
          if (e == 0) begin
            x.we = 1'b1; x.re = 1'b0; x.wdata = 8'h00;
          end else if (o == 0) begin
            x.we = 1'b0; x.re = 1'b1; x.wdata = 8'h00;
          end else begin
            x.we = 1'b1; x.re = 1'b0; x.wdata = e_rval[e] ? 8'h00 : 8'hFF;
          end
          op_q.push_back(x);
          k++;
        end
      end
    end
  endtask

  // Monitor: every SRAM op and every done rising edge is checked against the queues.
  op_exp_t  mo;
  res_exp_t mr;
  logic     busy_q = 1'b0, done_q = 1'b0;
  int       n_we = 0, n_re = 0, n_busy = 0;

  always @(negedge clk) begin
    if (rst) begin
      op_q.delete();
      res_q.delete();
      busy_q = 1'b0;
      done_q = 1'b0;
    end else begin
      if (busy && !busy_q) begin
        n_we = 0; n_re = 0; n_busy = 0;
      end
      if (busy)   n_busy++;
      if (mem_we) n_we++;
      if (mem_re) n_re++;
      if (mem_we || mem_re) begin
        if (op_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL mem_op: unexpected op we=%0b re=%0b addr=%0d (cycle %0d), none expected",
                   mem_we, mem_re, mem_addr, cyc);
        end else begin
          mo = op_q.pop_front();
          check("mem_op{we,re,addr,wdata,cycle}",
                {18'd0, mem_we, mem_re, mem_addr, (mem_we ? mem_wdata : 8'h00), 32'(cyc)},
                {18'd0, mo.we, mo.re, mo.addr, mo.wdata, 32'(mo.at)});
        end
      end
      if (done && !done_q) begin
        if (res_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL done_rise: done rose at cycle %0d, no run expected", cyc);
        end else begin
          mr = res_q.pop_front();
          check("done_cycle",    64'(cyc),          64'(mr.done_at));
          check("pass",          64'(pass),         64'(mr.pass_v));
          check("fail",          64'(fail),         64'(mr.fail_v));
          check("fail_addr",     64'(fail_addr),    64'(mr.faddr));
          check("fail_data",     64'(fail_data),    64'(mr.fdata));
          check("fail_expected", 64'(fail_expected),64'(mr.fexp));
          check("fail_element",  64'(fail_element), 64'(mr.felem));
          check("we_count",      64'(n_we),         64'd80);
          check("re_count",      64'(n_re),         64'd80);
          check("busy_cycles",   64'(n_busy),       64'd161);
        end
      end
      busy_q = busy;
      done_q = done;
    end
  end

  // Start sampled at the edge ending cycle t; returns in cycle t+1 with start low.
  task automatic issue_start(input int fm, input logic e_fail, input logic [AW-1:0] fa,
                             input logic [DW-1:0] fd, input logic [DW-1:0] fe,
                             input logic [2:0] fel, output int t);
    res_exp_t r;
    @(negedge clk);
    fault_mode = fm;
    t = cyc;
    r.pass_v  = !e_fail;
    r.fail_v  = e_fail;
    r.faddr   = fa;
    r.fdata   = fd;
    r.fexp    = fe;
    r.felem   = fel;
    r.done_at = t + RUN_OPS + 2;
    push_ops(t);
    res_q.push_back(r);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int t);
    while (!done && cyc < t + RUN_OPS + 20) @(negedge clk);
    check("done_seen", 64'(done), 64'd1);
    @(negedge clk);
  endtask

  int t;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy",   64'(busy),   64'd0);
    check("rst_done",   64'(done),   64'd0);
    check("rst_pass",   64'(pass),   64'd0);
    check("rst_fail",   64'(fail),   64'd0);
    check("rst_mem_ctl", {60'd0, mem_we, mem_re, 2'b00}, 64'd0);
    check("rst_mem_addr_wdata", {52'd0, mem_addr, mem_wdata}, 64'd0);
    check("rst_fail_regs", {41'd0, fail_addr, fail_data, fail_expected, fail_element}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fault-free run with a start pulse in the middle that must be ignored.
    issue_start(0, 1'b0, 4'd0, 8'h00, 8'h00, 3'd0, t);
    while (cyc < t + 20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(t);
    repeat (3) @(negedge clk);
    check("done_held", {62'd0, done, pass}, 64'd3);

    // Stuck-at-1 on bit 0 of address 5: first seen by the r0 of element 1.
    issue_start(1, 1'b1, 4'd5, 8'h01, 8'h00, 3'd1, t);
    wait_done(t);

    // Restart from DONE after a failure clears the failure state right away.
    issue_start(0, 1'b0, 4'd0, 8'h00, 8'h00, 3'd0, t);
    check("restart_fail",  64'(fail), 64'd0);
    check("restart_fregs", {41'd0, fail_addr, fail_data, fail_expected, fail_element}, 64'd0);
    check("restart_busy_done", {62'd0, busy, done}, 64'd2);
    wait_done(t);

    // Two transient faults: addr 9 in element 1 precedes addr 3 in element 2.
    issue_start(2, 1'b1, 4'd9, 8'h01, 8'h00, 3'd1, t);
    wait_done(t);

    // Reset in the middle of a failing run, then a clean rerun.
    issue_start(1, 1'b1, 4'd5, 8'h01, 8'h00, 3'd1, t);
    while (cyc < t + 50) @(negedge clk);
    check("pre_rst_fail", 64'(fail), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_mem_ctl", {62'd0, mem_we, mem_re}, 64'd0);
    check("midrst_busy_done", {62'd0, busy, done}, 64'd0);
    check("midrst_fail", 64'(fail), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue_start(0, 1'b0, 4'd0, 8'h00, 8'h00, 3'd0, t);
    wait_done(t);

    repeat (3) @(negedge clk);
    check("op_queue_left",  64'(op_q.size()),  64'd0);
    check("res_queue_left", 64'(res_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
